// File: rtl/instruction_memory_loader.sv
// Instruction memory loader: receives a framed byte stream, packs bytes into
// 32-bit little-endian words, writes them to instruction memory, and holds the
// CPU in reset until the whole program has arrived with a matching checksum.
module instruction_memory_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  ByteData,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        WriteEnable,
    output logic [31:0] WriteAddress,
    output logic [31:0] WriteData,
    output logic        CpuReset,
    output logic        LoadDone,
    output logic        LoadError
);

    // Word index must reach 2**ADDR_WIDTH itself, hence one extra bit.
    localparam int unsigned IDX_W     = ADDR_WIDTH + 1;
    localparam int unsigned MAX_WORDS = 2 ** ADDR_WIDTH;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CNT_LO = 3'd1;
    localparam logic [2:0] CNT_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] CHECK  = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    localparam logic [2:0] ERROR  = 3'd7;

    logic [2:0]       state,        stateNext;
    logic [15:0]      wordCount,    wordCountNext;
    logic [IDX_W-1:0] wordIndex,    wordIndexNext;
    logic [1:0]       byteLane,     byteLaneNext;
    logic [23:0]      wordBuf,      wordBufNext;
    logic [7:0]       checksum,     checksumNext;
    logic [31:0]      writeAddressNext;
    logic [31:0]      writeDataNext;

    logic             byteAccept;
    logic [15:0]      countFull;
    logic [IDX_W-1:0] idxInc;

    // State and datapath registers; all outputs come straight from flops.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            wordCount    <= '0;
            wordIndex    <= '0;
            byteLane     <= '0;
            wordBuf      <= '0;
            checksum     <= '0;
            ByteReady    <= 1'b1;
            WriteEnable  <= 1'b0;
            WriteAddress <= BASE_ADDR;
            WriteData    <= '0;
            CpuReset     <= 1'b1;
            LoadDone     <= 1'b0;
            LoadError    <= 1'b0;
        end else begin
            state        <= stateNext;
            wordCount    <= wordCountNext;
            wordIndex    <= wordIndexNext;
            byteLane     <= byteLaneNext;
            wordBuf      <= wordBufNext;
            checksum     <= checksumNext;
            ByteReady    <= (stateNext != WRITE);
            WriteEnable  <= (stateNext == WRITE);
            WriteAddress <= writeAddressNext;
            WriteData    <= writeDataNext;
            CpuReset     <= (stateNext != DONE);
            LoadDone     <= (stateNext == DONE);
            LoadError    <= (stateNext == ERROR);
        end
    end

    // Next-state and datapath update; a byte is consumed only outside WRITE.
    always_comb begin
        stateNext        = state;
        wordCountNext    = wordCount;
        wordIndexNext    = wordIndex;
        byteLaneNext     = byteLane;
        wordBufNext      = wordBuf;
        checksumNext     = checksum;
        writeAddressNext = WriteAddress;
        writeDataNext    = WriteData;
        byteAccept       = ByteValid && (state != WRITE);
        countFull        = {ByteData, wordCount[7:0]};
        idxInc           = wordIndex + IDX_W'(1);

        case (state)
            IDLE, DONE, ERROR: begin
                // Only a sync byte starts a new frame; everything else is dropped.
                if (byteAccept && (ByteData == SYNC_BYTE)) begin
                    stateNext     = CNT_LO;
                    wordCountNext = '0;
                    wordIndexNext = '0;
                    byteLaneNext  = '0;
                    wordBufNext   = '0;
                    checksumNext  = '0;
                end
            end
            CNT_LO: begin
                if (byteAccept) begin
                    wordCountNext[7:0] = ByteData;
                    checksumNext       = checksum ^ ByteData;
                    stateNext          = CNT_HI;
                end
            end
            CNT_HI: begin
                if (byteAccept) begin
                    wordCountNext = countFull;
                    checksumNext  = checksum ^ ByteData;
                    if (32'(countFull) > MAX_WORDS) begin
                        stateNext = ERROR;
                    end else if (countFull == 16'd0) begin
                        stateNext = CHECK;
                    end else begin
                        stateNext = DATA;
                    end
                end
            end
            DATA: begin
                if (byteAccept) begin
                    checksumNext = checksum ^ ByteData;
                    case (byteLane)
                        2'd0: wordBufNext[7:0]   = ByteData;
                        2'd1: wordBufNext[15:8]  = ByteData;
                        2'd2: wordBufNext[23:16] = ByteData;
                        default: begin
                            writeDataNext    = {ByteData, wordBuf};
                            writeAddressNext = BASE_ADDR + 32'({wordIndex, 2'b00});
                            stateNext        = WRITE;
                        end
                    endcase
                    byteLaneNext = byteLane + 2'd1;
                end
            end
            WRITE: begin
                wordIndexNext = idxInc;
                if (32'(idxInc) == 32'(wordCount)) begin
                    stateNext = CHECK;
                end else begin
                    stateNext = DATA;
                end
            end
            CHECK: begin
                if (byteAccept) begin
                    stateNext = (ByteData == checksum) ? DONE : ERROR;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Self-checking bench for instruction_memory_loader: expected memory writes
// are queued as bytes are driven and matched when WriteEnable pulses.
module tb_instruction_memory_loader;

    localparam logic [31:0] BASE = 32'h0;

    logic        CLK;
    logic        RESET;
    logic [7:0]  ByteData;
    logic        ByteValid;
    logic        ByteReady;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        CpuReset;
    logic        LoadDone;
    logic        LoadError;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t expQ[$];
    int  testsRun    = 0;
    int  testsFailed = 0;
    int  gapCycles   = 0;

    instruction_memory_loader #(
        .ADDR_WIDTH(10),
        .SYNC_BYTE (8'hA5),
        .BASE_ADDR (BASE)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ByteData    (ByteData),
        .ByteValid   (ByteValid),
        .ByteReady   (ByteReady),
        .WriteEnable (WriteEnable),
        .WriteAddress(WriteAddress),
        .WriteData   (WriteData),
        .CpuReset    (CpuReset),
        .LoadDone    (LoadDone),
        .LoadError   (LoadError)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock; any write strobe seen is matched against the scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge CLK);
        #1;
        if (WriteEnable === 1'b1) begin
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("FAIL unexpected_write: got addr=%h data=%h, none expected", WriteAddress, WriteData);
            end else begin
                e = expQ.pop_front();
                if (WriteAddress !== e.addr || WriteData !== e.data) begin
                    testsFailed++;
                    $display("FAIL write_match: got addr=%h data=%h, want addr=%h data=%h",
                             WriteAddress, WriteData, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int waitCnt;
        for (int g = 0; g < gapCycles; g++) tick();
        ByteData  = b;
        ByteValid = 1'b1;
        waitCnt   = 0;
        while (ByteReady !== 1'b1 && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        if (ByteReady !== 1'b1) begin
            testsRun++;
            testsFailed++;
            $display("FAIL byte_ready_timeout: ByteReady=%b, want 1 within 20 cycles", ByteReady);
        end
        tick();
        ByteValid = 1'b0;
        ByteData  = 8'h00;
    endtask

    task automatic sendHeader(input logic [15:0] n);
        sendByte(8'hA5);
        sendByte(n[7:0]);
        sendByte(n[15:8]);
    endtask

    task automatic sendWord(input logic [31:0] w, input int idx);
        wr_t e;
        e.addr = BASE + 32'(idx * 4);
        e.data = w;
        expQ.push_back(e);
        sendByte(w[7:0]);
        sendByte(w[15:8]);
        sendByte(w[23:16]);
        sendByte(w[31:24]);
    endtask

    task automatic doReset();
        ByteValid = 1'b0;
        ByteData  = 8'h00;
        RESET     = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        expQ.delete();
    endtask

    task automatic test_reset();
        doReset();
        testsRun++;
        if ({ByteReady, WriteEnable, CpuReset, LoadDone, LoadError} !== 5'b10100) begin
            testsFailed++;
            $display("FAIL reset_flags: got Rdy,WE,CpuRst,Done,Err=%b, want 10100",
                     {ByteReady, WriteEnable, CpuReset, LoadDone, LoadError});
        end
        testsRun++;
        if (WriteAddress !== BASE || WriteData !== 32'h0) begin
            testsFailed++;
            $display("FAIL reset_bus: got addr=%h data=%h, want %h/0", WriteAddress, WriteData, BASE);
        end
    endtask

    task automatic test_single_word();
        doReset();
        sendHeader(16'd1);
        sendWord(32'h0000_0013, 0);
        sendByte(8'h12);
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("FAIL single_writes: %0d writes missing, want 0", expQ.size());
        end
        testsRun++;
        if ({LoadDone, CpuReset, LoadError} !== 3'b100) begin
            testsFailed++;
            $display("FAIL single_status: got Done,CpuRst,Err=%b, want 100", {LoadDone, CpuReset, LoadError});
        end
    endtask

    task automatic sendTwoWordFrame(input logic [7:0] chk);
        sendHeader(16'd2);
        testsRun++;
        if (CpuReset !== 1'b1) begin
            testsFailed++;
            $display("FAIL load_cpu_reset: got CpuReset=%b, want 1", CpuReset);
        end
        sendWord(32'h0050_0093, 0);
        sendWord(32'h00A0_0113, 1);
        sendByte(chk);
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("FAIL two_word_writes: %0d writes missing, want 0", expQ.size());
        end
    endtask

    task automatic test_two_words();
        doReset();
        sendTwoWordFrame(8'h73);
        testsRun++;
        if ({LoadDone, CpuReset, LoadError} !== 3'b100) begin
            testsFailed++;
            $display("FAIL two_word_status: got Done,CpuRst,Err=%b, want 100", {LoadDone, CpuReset, LoadError});
        end
        repeat (3) tick();
        testsRun++;
        if (WriteAddress !== BASE + 32'd4 || WriteData !== 32'h00A0_0113) begin
            testsFailed++;
            $display("FAIL bus_hold: got addr=%h data=%h, want %h/00a00113", WriteAddress, WriteData, BASE + 32'd4);
        end
    endtask

    task automatic test_bad_checksum();
        doReset();
        sendTwoWordFrame(8'h74);
        testsRun++;
        if ({LoadDone, CpuReset, LoadError} !== 3'b011) begin
            testsFailed++;
            $display("FAIL bad_chk_status: got Done,CpuRst,Err=%b, want 011", {LoadDone, CpuReset, LoadError});
        end
    endtask

    task automatic test_zero_words();
        doReset();
        sendHeader(16'd0);
        sendByte(8'h00);
        testsRun++;
        if ({LoadDone, CpuReset, LoadError} !== 3'b100) begin
            testsFailed++;
            $display("FAIL zero_status: got Done,CpuRst,Err=%b, want 100", {LoadDone, CpuReset, LoadError});
        end
        testsRun++;
        if (WriteAddress !== BASE || WriteData !== 32'h0) begin
            testsFailed++;
            $display("FAIL zero_bus: got addr=%h data=%h, want untouched", WriteAddress, WriteData);
        end
    endtask

    task automatic test_oversize_and_recover();
        doReset();
        sendHeader(16'h0401);
        testsRun++;
        if ({LoadError, CpuReset, LoadDone} !== 3'b110) begin
            testsFailed++;
            $display("FAIL oversize: got Err,CpuRst,Done=%b, want 110", {LoadError, CpuReset, LoadDone});
        end
        sendByte(8'h00);
        testsRun++;
        if (LoadError !== 1'b1) begin
            testsFailed++;
            $display("FAIL error_discard: got LoadError=%b, want 1", LoadError);
        end
        sendByte(8'hA5);
        testsRun++;
        if ({LoadError, CpuReset} !== 2'b01) begin
            testsFailed++;
            $display("FAIL error_restart: got Err,CpuRst=%b, want 01", {LoadError, CpuReset});
        end
        sendByte(8'h01);
        sendByte(8'h00);
        sendWord(32'hCAFE_F00D, 0);
        sendByte(8'hC8);
        testsRun++;
        if ({LoadDone, CpuReset, LoadError} !== 3'b100 || expQ.size() != 0) begin
            testsFailed++;
            $display("FAIL recover_load: got Done,CpuRst,Err=%b pending=%0d, want 100 pending=0",
                     {LoadDone, CpuReset, LoadError}, expQ.size());
        end
    endtask

    task automatic test_max_count();
        doReset();
        sendHeader(16'h0400);
        testsRun++;
        if ({LoadError, LoadDone, ByteReady, CpuReset} !== 4'b0011) begin
            testsFailed++;
            $display("FAIL max_count: got Err,Done,Rdy,CpuRst=%b, want 0011",
                     {LoadError, LoadDone, ByteReady, CpuReset});
        end
    endtask

    task automatic test_restart_from_done();
        doReset();
        sendHeader(16'd0);
        sendByte(8'h00);
        sendByte(8'h3C);
        testsRun++;
        if ({LoadDone, CpuReset} !== 2'b10) begin
            testsFailed++;
            $display("FAIL done_discard: got Done,CpuRst=%b, want 10", {LoadDone, CpuReset});
        end
        sendByte(8'hA5);
        testsRun++;
        if ({LoadDone, CpuReset} !== 2'b01) begin
            testsFailed++;
            $display("FAIL done_restart: got Done,CpuRst=%b, want 01", {LoadDone, CpuReset});
        end
    endtask

    task automatic test_garbage_and_gaps();
        doReset();
        sendByte(8'h00);
        sendByte(8'hFF);
        testsRun++;
        if ({LoadDone, LoadError, CpuReset} !== 3'b001) begin
            testsFailed++;
            $display("FAIL garbage_idle: got Done,Err,CpuRst=%b, want 001", {LoadDone, LoadError, CpuReset});
        end
        gapCycles = 3;
        sendTwoWordFrame(8'h73);
        gapCycles = 0;
        testsRun++;
        if ({LoadDone, CpuReset, LoadError} !== 3'b100) begin
            testsFailed++;
            $display("FAIL gap_status: got Done,CpuRst,Err=%b, want 100", {LoadDone, CpuReset, LoadError});
        end
    endtask

    task automatic test_random_words();
        logic [31:0] w;
        logic [7:0]  chk;
        int          n;
        doReset();
        n   = 5;
        chk = 8'(n);
        sendHeader(16'(n));
        for (int i = 0; i < n; i++) begin
            w   = $urandom;
            chk = chk ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            sendWord(w, i);
        end
        sendByte(chk);
        testsRun++;
        if ({LoadDone, CpuReset, LoadError} !== 3'b100 || expQ.size() != 0) begin
            testsFailed++;
            $display("FAIL random_load: got Done,CpuRst,Err=%b pending=%0d, want 100 pending=0",
                     {LoadDone, CpuReset, LoadError}, expQ.size());
        end
    endtask

    task automatic test_reset_midframe();
        doReset();
        sendHeader(16'd2);
        sendWord(32'h0050_0093, 0);
        sendByte(8'h13);
        sendByte(8'h01);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        testsRun++;
        if ({ByteReady, WriteEnable, CpuReset, LoadDone, LoadError} !== 5'b10100) begin
            testsFailed++;
            $display("FAIL midframe_flags: got Rdy,WE,CpuRst,Done,Err=%b, want 10100",
                     {ByteReady, WriteEnable, CpuReset, LoadDone, LoadError});
        end
        testsRun++;
        if (WriteAddress !== BASE || WriteData !== 32'h0) begin
            testsFailed++;
            $display("FAIL midframe_bus: got addr=%h data=%h, want %h/0", WriteAddress, WriteData, BASE);
        end
        RESET = 1'b0;
        expQ.delete();
    endtask

    initial begin
        RESET     = 1'b1;
        ByteValid = 1'b0;
        ByteData  = 8'h00;
        test_reset();
        test_single_word();
        test_two_words();
        test_bad_checksum();
        test_zero_words();
        test_oversize_and_recover();
        test_max_count();
        test_restart_from_done();
        test_garbage_and_gaps();
        test_random_words();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Hard stop in case a wait ever escapes its bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
